// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (IF)
// and load/store (LS). Each transaction runs IDLE -> ISSUE -> [WAIT] -> RESP, with
// every output driven straight from a register.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1    // legal range 1..4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ack,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_ls
);

    localparam int CW = 3;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

    state_t          r_state;
    logic            r_prio_ls;    // 1: LS wins the next tie
    logic            r_op_we;      // store flag, kept after mem_we drops
    logic [CW-1:0]   r_cnt;
    logic            r_if_ack;
    logic            r_ls_ack;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_ls_rdata;
    logic            r_mem_en;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_busy;
    logic            r_grant_ls;

    logic            w_any_req;
    logic            w_pick_ls;
    logic            w_pick_we;

    // Pick the winner in IDLE: a lone requester, else whoever the pointer favours.
    always_comb begin
        w_any_req = if_req | ls_req;
        w_pick_ls = ls_req & (~if_req | r_prio_ls);
        w_pick_we = w_pick_ls & ls_we;
    end

    // Transaction sequencer; strobes and acks default low so each lasts one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_prio_ls   <= 1'b1;
            r_op_we     <= 1'b0;
            r_cnt       <= '0;
            r_if_ack    <= 1'b0;
            r_ls_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_grant_ls  <= 1'b0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_grant_ls  <= w_pick_ls;
                        r_prio_ls   <= ~w_pick_ls;
                        r_mem_addr  <= w_pick_ls ? ls_addr : if_addr;
                        r_mem_wdata <= w_pick_ls ? ls_wdata : '0;
                        r_op_we     <= w_pick_we;
                        r_mem_we    <= w_pick_we;
                        r_mem_en    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (r_op_we) begin
                        // Stores need no read data: acknowledge right away.
                        if (r_grant_ls) r_ls_ack <= 1'b1;
                        else            r_if_ack <= 1'b1;
                        r_state <= StResp;
                    end else begin
                        r_cnt   <= CW'(MEM_LAT - 1);
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (r_cnt == '0) begin
                        if (r_grant_ls) begin
                            r_ls_rdata <= mem_rdata;
                            r_ls_ack   <= 1'b1;
                        end else begin
                            r_if_rdata <= mem_rdata;
                            r_if_ack   <= 1'b1;
                        end
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StResp: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        if_ack    = r_if_ack;
        if_rdata  = r_if_rdata;
        ls_ack    = r_ls_ack;
        ls_rdata  = r_ls_rdata;
        mem_en    = r_mem_en;
        mem_we    = r_mem_we;
        mem_addr  = r_mem_addr;
        mem_wdata = r_mem_wdata;
        busy      = r_busy;
        grant_ls  = r_grant_ls;
    end

endmodule
